sqrt_square_check: RTL and testbench



---
 rtl/sqrt_pkg.sv | 23 ++
 rtl/sqrt_square_check.sv | 170 +++++++++++++++++
 tb/tb_sqrt_square_check.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_pkg
//   Shared definitions for the iterative Sqrt unit and its companion
//   sqrt_square_check. Both blocks use the same three-state control style
//   (IDLE -> CALC -> DONE), so the state encoding lives here to keep the two
//   in step. The helper sum_width gives the width needed to hold
//   root*root + rem for W-bit operands without overflow.
// ---------------------------------------------------------------------------
package sqrt_pkg;

  // Control states shared by the Sqrt unit and the square checker.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // (2^W-1)^2 + (2^W-1) < 2^(2W+1), so 2W+1 bits never overflow.
  function automatic int sum_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/sqrt_square_check.sv
// ---------------------------------------------------------------------------
// sqrt_square_check
//   Iterative shift-add squarer that rebuilds a radicand from a square-root
//   result: o_sum = root*root + rem. It then flags whether that rebuilt value
//   equals the original radicand (scaled by the fractional bits used by the
//   matching Sqrt instance). One multiplier bit is processed per clock, so a
//   result appears a fixed TOTAL_WIDTH+1 cycles after an accepted start.
//
// Parameters
//   TOTAL_WIDTH     width of radicand, root and remainder operands
//   FRACTION_WIDTH  fractional bits of the matching Sqrt; compare target is
//                   i_rad << FRACTION_WIDTH (must be <= TOTAL_WIDTH+1)
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset, highest priority
//   i_start  start request, only looked at in IDLE
//   i_root   root operand, latched at accepted start
//   i_rem    remainder operand, latched at accepted start
//   i_rad    original radicand, latched at accepted start
//   o_busy   high while the shift-add loop runs
//   o_valid  one-cycle pulse when o_sum / o_match are fresh
//   o_sum    root*root + rem, held until the next result
//   o_match  o_sum equals the zero-extended scaled radicand
// ---------------------------------------------------------------------------
module sqrt_square_check
  import sqrt_pkg::*;
#(
  parameter int TOTAL_WIDTH    = 8,
  parameter int FRACTION_WIDTH = 0
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic [TOTAL_WIDTH-1:0]              i_root,
  input  logic [TOTAL_WIDTH-1:0]              i_rem,
  input  logic [TOTAL_WIDTH-1:0]              i_rad,
  output logic                                o_busy,
  output logic                                o_valid,
  output logic [sum_width(TOTAL_WIDTH)-1:0]   o_sum,
  output logic                                o_match
);

  localparam int SUM_WIDTH   = sum_width(TOTAL_WIDTH);
  // One spare bit so the counter can step past TOTAAL-1 without wrapping
  // when TOTAL_WIDTH is a power of two.
  localparam int COUNT_WIDTH = $clog2(TOTAL_WIDTH) + 1;
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TOTAL_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  // Registered state
  state_t                   r_state;
  logic [TOTAL_WIDTH-1:0]   r_mcand;
  logic [TOTAL_WIDTH-1:0]   r_mplier;
  logic [TOTAL_WIDTH-1:0]   r_rad;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [SUM_WIDTH-1:0]     r_acc;
  logic [SUM_WIDTH-1:0]     r_sum;
  logic                     r_match;

  // Next-state values
  state_t                   w_stateNext;
  logic [TOTAL_WIDTH-1:0]   w_mcandNext;
  logic [TOTAL_WIDTH-1:0]   w_mplierNext;
  logic [TOTAL_WIDTH-1:0]   w_radNext;
  logic [COUNT_WIDTH-1:0]   w_countNext;
  logic [SUM_WIDTH-1:0]     w_accNext;
  logic [SUM_WIDTH-1:0]     w_sumNext;
  logic                     w_matchNext;

  // Datapath helpers
  logic [SUM_WIDTH-1:0]     w_partial;
  logic [SUM_WIDTH-1:0]     w_accStep;
  logic [SUM_WIDTH-1:0]     w_target;
  logic                     w_lastStep;

  // The partial product for the current multiplier bit is the multiplicand
  // weighted by the bit position, which is exactly the step counter.
  assign w_partial  = SUM_WIDTH'(r_mcand) << r_count;

  // Accumulator value after this CALC step: add the partial product only
  // when the multiplier bit currently at the bottom of the shifter is set.
  assign w_accStep  = r_mplier[0] ? (r_acc + w_partial) : r_acc;

  // The Sqrt unit returns a root scaled by 2^FRACTION_WIDTH, so its square
  // carries twice that scaling; rebuilding against the shifted radicand
  // keeps the comparison in the same fixed-point frame.
  assign w_target   = SUM_WIDTH'(r_rad) << FRACTION_WIDTH;

  assign w_lastStep = (r_count == LAST_COUNT);

  // Next-state and datapath update. Everything holds by default; IDLE loads
  // the operands on a start, CALC runs one shift-add step per clock, and the
  // final CALC step also publishes the result so it is already on o_sum /
  // o_match during the DONE cycle. The result registers are never cleared
  // outside reset, so they keep the previous answer between operations.
  always_comb begin
    w_stateNext  = r_state;
    w_mcandNext  = r_mcand;
    w_mplierNext = r_mplier;
    w_radNext    = r_rad;
    w_countNext  = r_count;
    w_accNext    = r_acc;
    w_sumNext    = r_sum;
    w_matchNext  = r_match;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_mcandNext  = i_root;
          w_mplierNext = i_root;
          w_accNext    = SUM_WIDTH'(i_rem);
          w_radNext    = i_rad;
          w_countNext  = '0;
          w_stateNext  = S_CALC;
        end
      end

      S_CALC: begin
        w_accNext    = w_accStep;
        w_mplierNext = r_mplier >> 1;
        w_countNext  = r_count + COUNT_ONE;
        if (w_lastStep) begin
          w_sumNext   = w_accStep;
          w_matchNext = (w_accStep == w_target);
          w_stateNext = S_DONE;
        end
      end

      S_DONE: begin
        w_stateNext = S_IDLE;
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset wins over everything, so a reset
  // in the middle of CALC simply drops the operation and no DONE follows.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rad    <= '0;
      r_count  <= '0;
      r_acc    <= '0;
      r_sum    <= '0;
      r_match  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_mcand  <= w_mcandNext;
      r_mplier <= w_mplierNext;
      r_rad    <= w_radNext;
      r_count  <= w_countNext;
      r_acc    <= w_accNext;
      r_sum    <= w_sumNext;
      r_match  <= w_matchNext;
    end
  end

  // Handshake outputs are pure state decodes, so reset forces them low.
  assign o_busy  = (r_state == S_CALC);
  assign o_valid = (r_state == S_DONE);
  assign o_sum   = r_sum;
  assign o_match = r_match;

endmodule

// File: tb/tb_sqrt_square_check.sv
// ---------------------------------------------------------------------------
// tb_sqrt_square_check
//   Directed bench for sqrt_square_check (TOTAL_WIDTH=8, FRACTION_WIDTH=0).
//   Expected values are hand-computed constants; the chained sweep derives
//   root/rem from a bench-side integer square root.
// ---------------------------------------------------------------------------
module tb_sqrt_square_check;

  localparam int W  = 8;
  localparam int SW = 2 * W + 1;

  logic          i_clk;
  logic          i_rst;
  logic          i_start;
  logic [W-1:0]  i_root;
  logic [W-1:0]  i_rem;
  logic [W-1:0]  i_rad;
  logic          o_busy;
  logic          o_valid;
  logic [SW-1:0] o_sum;
  logic          o_match;

  int errors;
  int checks;
  int cycle;
  int busyTotal;
  int validTotal;
  int startCycle;
  int busyBase;
  int validBase;
  int lat;

  sqrt_square_check #(
    .TOTAL_WIDTH   (W),
    .FRACTION_WIDTH(0)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(i_start),
    .i_root (i_root),
    .i_rem  (i_rem),
    .i_rad  (i_rad),
    .o_busy (o_busy),
    .o_valid(o_valid),
    .o_sum  (o_sum),
    .o_match(o_match)
  );

  // 10 ns clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Free-running edge counter used for latency measurements.
  always @(posedge i_clk) cycle <= cycle + 1;

  // Running totals of busy and valid cycles, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_busy)  busyTotal  <= busyTotal + 1;
    if (o_valid) validTotal <= validTotal + 1;
  end

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present one start pulse with operands at a negedge; return one cycle
  // later with i_start low (the DUT is then in CALC).
  task automatic applyStimulus(input logic [W-1:0] root, input logic [W-1:0] rem,
                               input logic [W-1:0] rad);
    @(negedge i_clk);
    i_root     = root;
    i_rem      = rem;
    i_rad      = rad;
    i_start    = 1'b1;
    startCycle = cycle;
    busyBase   = busyTotal;
    @(negedge i_clk);
    i_start    = 1'b0;
  endtask

  // Wait (bounded) for o_valid; returns cycles since the start was driven.
  task automatic waitValid(input string tag, output int latency);
    int guard;
    guard = 0;
    while (!o_valid && guard < 40) begin
      @(negedge i_clk);
      guard++;
    end
    checkOutput({tag, "_valid_seen"}, {31'd0, o_valid}, 32'd1);
    latency = cycle - startCycle;
  endtask

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    for (int k = 0; k * k <= x; k++) r = k;
    return r;
  endfunction

  initial begin
    int root;
    int c1;
    int c2;
    int guard;
    errors     = 0;
    checks     = 0;
    cycle      = 0;
    busyTotal  = 0;
    validTotal = 0;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_root     = '0;
    i_rem      = '0;
    i_rad      = '0;

    repeat (3) @(negedge i_clk);
    checkOutput("reset_busy",  {31'd0, o_busy},  32'd0);
    checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset_sum",   32'(o_sum),       32'd0);
    checkOutput("reset_match", {31'd0, o_match}, 32'd0);
    i_rst = 1'b0;

    // 11^2 + 0 = 121
    $display("[TB] root=11 rem=0 rad=121");
    applyStimulus(8'd11, 8'd0, 8'd121);
    waitValid("op121", lat);
    checkOutput("op121_latency", 32'(lat), 32'd9);
    checkOutput("op121_sum", 32'(o_sum), 32'd121);
    checkOutput("op121_match", {31'd0, o_match}, 32'd1);
    checkOutput("op121_busy_cycles", 32'(busyTotal - busyBase), 32'd8);

    // 14^2 + 4 = 200
    applyStimulus(8'd14, 8'd4, 8'd200);
    waitValid("op200", lat);
    checkOutput("op200_sum", 32'(o_sum), 32'd200);
    checkOutput("op200_match", {31'd0, o_match}, 32'd1);

    // 15^2 + 30 = 255
    applyStimulus(8'd15, 8'd30, 8'd255);
    waitValid("op255", lat);
    checkOutput("op255_sum", 32'(o_sum), 32'd255);
    checkOutput("op255_match", {31'd0, o_match}, 32'd1);

    // 15^2 + 29 = 254, not 255
    applyStimulus(8'd15, 8'd29, 8'd255);
    waitValid("op254", lat);
    checkOutput("op254_sum", 32'(o_sum), 32'd254);
    checkOutput("op254_match", {31'd0, o_match}, 32'd0);

    // all ones: 255^2 + 255 = 65280
    applyStimulus(8'd255, 8'd255, 8'd255);
    waitValid("opmax", lat);
    checkOutput("opmax_sum", 32'(o_sum), 32'd65280);
    checkOutput("opmax_bit16", {31'd0, o_sum[16]}, 32'd0);
    checkOutput("opmax_match", {31'd0, o_match}, 32'd0);

    // root 0 returns rem
    applyStimulus(8'd0, 8'd7, 8'd7);
    waitValid("root0", lat);
    checkOutput("root0_sum", 32'(o_sum), 32'd7);
    checkOutput("root0_match", {31'd0, o_match}, 32'd1);

    // result holds while idle
    repeat (4) @(negedge i_clk);
    checkOutput("hold_sum", 32'(o_sum), 32'd7);
    checkOutput("hold_match", {31'd0, o_match}, 32'd1);
    checkOutput("hold_valid", {31'd0, o_valid}, 32'd0);

    // second start 3 cycles into CALC is ignored; inputs change after start
    $display("[TB] start during CALC");
    applyStimulus(8'd13, 8'd0, 8'd169);
    repeat (2) @(negedge i_clk);
    i_root  = 8'd1;
    i_rem   = 8'd0;
    i_rad   = 8'd1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    waitValid("ignore", lat);
    checkOutput("ignore_latency", 32'(lat), 32'd9);
    checkOutput("ignore_sum", 32'(o_sum), 32'd169);
    checkOutput("ignore_match", {31'd0, o_match}, 32'd1);
    checkOutput("ignore_busy_cycles", 32'(busyTotal - busyBase), 32'd8);
    @(negedge i_clk);
    checkOutput("ignore_idle_after", {31'd0, o_busy}, 32'd0);

    // reset 4 cycles into CALC
    $display("[TB] reset during CALC");
    applyStimulus(8'd11, 8'd0, 8'd121);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    validBase = validTotal;
    @(negedge i_clk);
    checkOutput("rst_busy",  {31'd0, o_busy},  32'd0);
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_sum",   32'(o_sum),       32'd0);
    checkOutput("rst_match", {31'd0, o_match}, 32'd0);
    i_rst = 1'b0;
    repeat (12) @(negedge i_clk);
    checkOutput("rst_no_valid", 32'(validTotal - validBase), 32'd0);
    applyStimulus(8'd11, 8'd0, 8'd121);
    waitValid("after_rst", lat);
    checkOutput("after_rst_sum", 32'(o_sum), 32'd121);
    checkOutput("after_rst_match", {31'd0, o_match}, 32'd1);

    // every radicand with its integer root/remainder must rebuild exactly
    $display("[TB] sweep of all radicands");
    for (int rad = 0; rad < 256; rad++) begin
      root = isqrt(rad);
      applyStimulus(8'(root), 8'(rad - root * root), 8'(rad));
      waitValid("sweep", lat);
      checkOutput($sformatf("sweep_match_%0d", rad), {31'd0, o_match}, 32'd1);
    end

    // start held high: one result every W+2 cycles
    $display("[TB] start held high");
    @(negedge i_clk);
    i_root  = 8'd11;
    i_rem   = 8'd0;
    i_rad   = 8'd121;
    i_start = 1'b1;
    startCycle = cycle;
    waitValid("held_first", lat);
    c1 = cycle;
    @(negedge i_clk);
    guard = 0;
    while (!o_valid && guard < 40) begin
      @(negedge i_clk);
      guard++;
    end
    c2 = cycle;
    checkOutput("held_second_valid", {31'd0, o_valid}, 32'd1);
    checkOutput("held_period", 32'(c2 - c1), 32'd10);
    checkOutput("held_sum", 32'(o_sum), 32'd121);
    i_start = 1'b0;
    repeat (12) @(negedge i_clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
